// File: rtl/serial_word_deserializer_pkg.sv
// Shared definitions for the serial word deserializer: default word width and
// the receive FSM state encoding.
package serial_word_deserializer_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/serial_word_deserializer_out_reg.sv
// 1-entry valid/ready holding register for assembled words; drops a completed
// word when the entry is still occupied and records that in a sticky flag.
module ser_out_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    input  logic             word_ready,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             overrun
);

    logic drop;

    assign drop = load && word_valid && !word_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load && (!word_valid || word_ready)) begin
                word_out   <= load_word;
                word_valid <= 1'b1;
            end else if (!load && word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            // A drop in the same cycle as a clear must stay visible.
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel receiver: aligns to frame_sync, assembles LSB-first words
// and hands them to a valid/ready output register.
module serial_word_deserializer
    import serial_word_deserializer_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEFAULT,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             locked,
    output logic             sync_err,
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic             take, restart, complete, sync_err_d;
    logic [WIDTH-1:0] full_word;

    // In HUNT only a framed bit is taken, and it always starts a new word.
    assign take       = bit_valid && (state_q == SHIFT || frame_sync);
    assign sync_err_d = bit_valid && frame_sync && state_q == SHIFT && bit_cnt != '0;
    assign restart    = bit_valid && frame_sync && (state_q == HUNT || bit_cnt != '0);
    assign complete   = take && !restart && bit_cnt == LAST_BIT;
    assign full_word  = {serial_in, shift_reg[WIDTH-2:0]};
    assign locked     = (state_q == SHIFT);

    // NOTE: every variable driven here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        if (state_q == HUNT && bit_valid && frame_sync) begin
            state_d = SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            bit_cnt   <= '0;
            shift_reg <= '0;
            sync_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_err <= sync_err_d;
            if (take) begin
                if (restart) begin
                    shift_reg <= WIDTH'(serial_in);
                    bit_cnt   <= CNT_W'(1);
                end else begin
                    shift_reg[bit_cnt] <= serial_in;
                    bit_cnt            <= complete ? '0 : bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    ser_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (complete),
        .load_word  (full_word),
        .word_ready (word_ready),
        .clr_overrun(clr_overrun),
        .word_out   (word_out),
        .word_valid (word_valid),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench for serial_word_deserializer: words expected at the output are
// queued as they are sent and compared when the consumer handshake takes them.
module tb_serial_word_deserializer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             serial_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             frame_sync = 1'b0;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready = 1'b1;
    logic             locked;
    logic             sync_err;
    logic             overrun;
    logic             clr_overrun = 1'b0;

    int passed = 0;
    int total  = 0;
    int pops   = 0;
    int sync_err_cnt = 0;
    logic [WIDTH-1:0] exp_q[$];

    serial_word_deserializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .frame_sync (frame_sync),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .locked     (locked),
        .sync_err   (sync_err),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs; returns just after the sampling edge.
    task automatic drive(input logic b, input logic fs, input logic v);
        serial_in  = b;
        frame_sync = fs;
        bit_valid  = v;
        @(posedge clk);
        #1;
        bit_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input logic sync, input logic expect_out);
        if (expect_out) exp_q.push_back(w);
        for (int i = 0; i < WIDTH; i++) drive(w[i], sync && (i == 0), 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_word_out"}, 32'(word_out), 32'h0);
        check({tag, "_word_valid"}, 32'(word_valid), 32'h0);
        check({tag, "_locked"}, 32'(locked), 32'h0);
        check({tag, "_sync_err"}, 32'(sync_err), 32'h0);
        check({tag, "_overrun"}, 32'(overrun), 32'h0);
    endtask

    // Scoreboard side: a word leaves the DUT when valid && ready at the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sync_err) sync_err_cnt++;
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(word_out), 32'hFFFF_FFFF);
                end else begin
                    check("word_out_handshake", 32'(word_out), 32'(exp_q.pop_front()));
                    pops++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Test 1: reset, then 4'hD framed from idle
        #2;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(4'hD);
        drive(1'b1, 1'b1, 1'b1);
        check("t1_locked", 32'(locked), 32'h1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        check("t1_valid_before_last", 32'(word_valid), 32'h0);
        drive(1'b1, 1'b0, 1'b1);
        check("t1_valid_after_last", 32'(word_valid), 32'h1);
        check("t1_word_out", 32'(word_out), 32'hD);
        drive(1'b0, 1'b0, 1'b0);

        // Test 2: back-to-back words, sync only on the first
        send_word(4'h3, 1'b1, 1'b1);
        send_word(4'hA, 1'b0, 1'b1);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        check("t2_pops", 32'(pops), 32'd3);
        check("t2_sync_err_cnt", 32'(sync_err_cnt), 32'd0);
        check("t2_overrun", 32'(overrun), 32'h0);

        // Test 3: gaps between bits carry junk data and frame_sync
        exp_q.push_back(4'h6);
        for (int i = 0; i < WIDTH; i++) begin
            drive(1'(4'h6 >> i), 1'b0, 1'b1);
            drive(~1'(4'h6 >> i), 1'b1, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0);
        check("t3_pops", 32'(pops), 32'd4);
        check("t3_sync_err_cnt", 32'(sync_err_cnt), 32'd0);

        // Test 4: frame_sync on the third bit restarts the word as 4'h9
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        exp_q.push_back(4'h9);
        drive(1'b1, 1'b1, 1'b1);
        check("t4_sync_err_pulse", 32'(sync_err), 32'h1);
        drive(1'b0, 1'b0, 1'b1);
        check("t4_sync_err_clear", 32'(sync_err), 32'h0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        check("t4_pops", 32'(pops), 32'd5);
        check("t4_sync_err_cnt", 32'(sync_err_cnt), 32'd1);

        // Test 5: consumer stalled, second word dropped
        word_ready = 1'b0;
        send_word(4'h1, 1'b0, 1'b1);
        send_word(4'h2, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("t5_word_out_held", 32'(word_out), 32'h1);
        check("t5_word_valid_held", 32'(word_valid), 32'h1);
        check("t5_overrun_set", 32'(overrun), 32'h1);
        clr_overrun = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        clr_overrun = 1'b0;
        check("t5_overrun_cleared", 32'(overrun), 32'h0);
        word_ready = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        check("t5_pops", 32'(pops), 32'd6);
        check("t5_valid_drained", 32'(word_valid), 32'h0);

        // Test 6: reset mid-word discards the partial word
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("t6_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_word(4'hF, 1'b1, 1'b1);
        check("t6_word_out", 32'(word_out), 32'hF);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        check("t6_pops", 32'(pops), 32'd7);

        // Test 7: unframed bits after reset never lock or produce words
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'(i & 1), 1'b0, 1'b1);
            check("t7_word_valid", 32'(word_valid), 32'h0);
        end
        check("t7_locked", 32'(locked), 32'h0);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_sync_err_cnt", 32'(sync_err_cnt), 32'd1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
